// File: rtl/debounce_pkg.sv
// Shared definitions for the multi-channel debouncer: FSM state encoding and
// the elaboration-time legality check for the timing parameters.
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DLY0 = 2'b01,
        ONE  = 2'b10,
        DLY1 = 2'b11
    } db_state_e;

    function automatic bit db_params_ok(input int db_cycles, input int sync_stages);
        return (db_cycles >= 2) && (sync_stages >= 2);
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounced channel: synchroniser, four-state debounce FSM, hold counter
// and registered level / press / release / long-press outputs.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int DB_CYCLES   = 2_000_000,
    parameter int LONG_CYCLES = 50_000_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sw,
    input  logic inv,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long
);

    localparam int CNT_W  = $clog2(DB_CYCLES);
    localparam int HOLD_W = (LONG_CYCLES > 0) ? $clog2(LONG_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(LONG_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    db_state_e              r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [HOLD_W-1:0]      r_hold;
    logic                   r_long_done;
    logic                   r_level;
    logic                   r_press;
    logic                   r_release;
    logic                   r_long;

    logic w_sw_s;
    logic w_held;
    logic w_leaving;

    // Loading the polarity bit on reset makes the synchronised input read inactive.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= {SYNC_STAGES{inv}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], sw};
        end
    end

    assign w_sw_s    = r_sync[SYNC_STAGES-1] ^ inv;
    assign w_held    = (r_state == ONE) || (r_state == DLY1);
    assign w_leaving = (r_state == DLY1) && !w_sw_s && (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_hold      <= '0;
            r_long_done <= 1'b0;
            r_level     <= 1'b0;
            r_press     <= 1'b0;
            r_release   <= 1'b0;
            r_long      <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;

            // Hold time keeps running through a DLY1 glitch and saturates.
            if (w_held && (r_hold != HOLD_MAX)) begin
                r_hold <= r_hold + 1'b1;
            end

            // The final DLY1 cycle goes to IDLE, so no long pulse can join a release.
            if ((LONG_CYCLES > 0) && w_held && !w_leaving && !r_long_done &&
                (r_hold == HOLD_FIRE)) begin
                r_long      <= 1'b1;
                r_long_done <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (w_sw_s) begin
                        r_state <= DLY0;
                        r_cnt   <= '0;
                    end
                end
                DLY0: begin
                    if (!w_sw_s) begin
                        r_state <= IDLE;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= ONE;
                        r_level <= 1'b1;
                        r_press <= 1'b1;
                        r_hold  <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ONE: begin
                    if (!w_sw_s) begin
                        r_state <= DLY1;
                        r_cnt   <= '0;
                    end
                end
                DLY1: begin
                    if (w_sw_s) begin
                        r_state <= ONE;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state     <= IDLE;
                        r_level     <= 1'b0;
                        r_release   <= 1'b1;
                        r_long_done <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_level <= 1'b0;
                end
            endcase
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_long    = r_long;

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel debouncer: CH independent debounce_chan instances with a
// per-channel polarity taken from INV_MASK.
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int            CH          = 4,
    parameter int            DB_CYCLES   = 2_000_000,
    parameter int            LONG_CYCLES = 50_000_000,
    parameter int            SYNC_STAGES = 2,
    parameter logic [CH-1:0] INV_MASK    = {CH{1'b0}}
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CH-1:0] sw,
    output logic [CH-1:0] db_level,
    output logic [CH-1:0] press_tick,
    output logic [CH-1:0] release_tick,
    output logic [CH-1:0] long_tick
);

    if (!db_params_ok(DB_CYCLES, SYNC_STAGES)) begin : g_bad_params
        $error("debounce_multi: DB_CYCLES and SYNC_STAGES must both be >= 2");
    end

    logic [CH-1:0] w_level;
    logic [CH-1:0] w_press;
    logic [CH-1:0] w_release;
    logic [CH-1:0] w_long;

    for (genvar g = 0; g < CH; g++) begin : g_chan
        debounce_chan #(
            .DB_CYCLES  (DB_CYCLES),
            .LONG_CYCLES(LONG_CYCLES),
            .SYNC_STAGES(SYNC_STAGES)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .sw       (sw[g]),
            .inv      (INV_MASK[g]),
            .o_level  (w_level[g]),
            .o_press  (w_press[g]),
            .o_release(w_release[g]),
            .o_long   (w_long[g])
        );
    end

    assign db_level     = w_level;
    assign press_tick   = w_press;
    assign release_tick = w_release;
    assign long_tick    = w_long;

endmodule
